// File: rtl/axi_wr_slave_mem_if.sv
// AXI3 write-channel bundle (AW, W, B) for axi_wr_slave_mem.
interface axi_wr_slave_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_wr_slave_mem.sv
// AXI3 write slave: one burst at a time into a byte-strobed memory, with a registered debug read port.
// Define AXI_WR_OOR_SLVERR_EN to flag out-of-range beats with SLVERR instead of aliasing modulo DEPTH.
module axi_wr_slave_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  axi_wr_slave_mem_if.slave        bus,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]        dbg_data_o
);

  localparam int          LB = $clog2(DATA_W / 8);
  localparam int          IW = $clog2(DEPTH);
  localparam int unsigned NB = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mask_q, mask_d;
  logic [3:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ill_q, ill_d;
  logic [DATA_W-1:0] dbg_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aw_hs, w_hs, b_hs;
  logic              oor, wr_en, aw_ill;
  logic [ADDR_W-1:0] incr;
  logic [IW-1:0]     mem_idx;

  assign aw_hs   = bus.awvalid & bus.awready;
  assign w_hs    = bus.wvalid & bus.wready;
  assign b_hs    = bus.bvalid & bus.bready;
  assign incr    = ADDR_W'(1) << size_q;
  assign mem_idx = IW'(addr_q >> LB);

`ifdef AXI_WR_OOR_SLVERR_EN
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  assign oor = (addr_q >> LB) >= DEPTH_A;
`else
  assign oor = 1'b0;
`endif

  assign wr_en = w_hs & ~ill_q & ~oor;

  assign aw_ill = (bus.awburst == 2'b11) || (32'(bus.awsize) > LB) ||
                  ((bus.awburst == 2'b10) && !(bus.awlen == 4'd1 || bus.awlen == 4'd3 ||
                                               bus.awlen == 4'd7 || bus.awlen == 4'd15));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          id_d    = bus.awid;
          addr_d  = bus.awaddr;
          len_d   = bus.awlen;
          size_d  = bus.awsize;
          burst_d = bus.awburst;
          // wrap window mask = span-1, span = beats << size
          mask_d  = ((ADDR_W'(bus.awlen) + ADDR_W'(1)) << bus.awsize) - ADDR_W'(1);
          cnt_d   = '0;
          err_d   = aw_ill;
          ill_d   = aw_ill;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          case (burst_q)
            2'b00:   addr_d = addr_q;
            2'b10:   addr_d = (addr_q & ~mask_q) | ((addr_q + incr) & mask_q);
            default: addr_d = addr_q + incr;
          endcase
          err_d = err_q | (bus.wid != id_q) | oor | (bus.wlast != (cnt_q == len_q));
          if (cnt_q == len_q) state_d = S_RESP;
          else                cnt_d   = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (b_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ill_q   <= 1'b0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
      dbg_q   <= mem[dbg_addr_i];
    end
  end

  // Memory has no reset; contents survive RESET by design.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.wstrb[i]) mem[mem_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  assign bus.awready = (state_q == S_IDLE) & ~rst_i;
  assign bus.wready  = (state_q == S_DATA);
  assign bus.bvalid  = (state_q == S_RESP);
  assign bus.bid     = id_q;
  assign bus.bresp   = {err_q, 1'b0};
  assign dbg_data_o  = dbg_q;

endmodule
